// File: rtl/system86_bus_pkg.sv
// Shared definitions for the System 86 time-multiplexed bus responder:
// phase encodings, decode regions, bus widths and pipeline depth.
package system86_bus_pkg;

  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned RAM_AW     = 12;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PIPE_DEPTH = 2;

  localparam logic [DATA_W-1:0] OPEN_BUS = '1;

  typedef enum logic [1:0] {
    PH_MAIN = 2'd0,
    PH_REL1 = 2'd1,
    PH_SUB  = 2'd2,
    PH_REL3 = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    RGN_RAM0  = 2'd0,
    RGN_RAM1  = 2'd1,
    RGN_LATCH = 2'd2
  } region_e;

  // Any latch strobe low wins over the RAM decode.
  function automatic region_e decode_region(input logic a_top, input logic nl0, input logic nl1);
    if (!nl0 || !nl1) return RGN_LATCH;
    return a_top ? RGN_RAM1 : RGN_RAM0;
  endfunction

endpackage

// File: rtl/shared_bus_responder_if.sv
// Shared bus, RAM port and result signals of the responder.
interface shared_bus_responder_if;
  import system86_bus_pkg::*;

  logic [ADDR_W-1:0] A;
  logic              RnW;
  logic              nLATCH0;
  logic              nLATCH1;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] RAM_Q;

  logic [RAM_AW-1:0] RAM_A;
  logic              RAM_WE;
  logic [DATA_W-1:0] RAM_D;
  logic              RAM_SEL;
  logic [1:0]        PHASE;
  logic [DATA_W-1:0] MDO;
  logic [DATA_W-1:0] SDO;
  logic              MVALID;
  logic              SVALID;
  logic [DATA_W-1:0] LATCH0_Q;
  logic [DATA_W-1:0] LATCH1_Q;

  modport master (
    output A, RnW, nLATCH0, nLATCH1, D, RAM_Q,
    input  RAM_A, RAM_WE, RAM_D, RAM_SEL, PHASE, MDO, SDO, MVALID, SVALID, LATCH0_Q, LATCH1_Q
  );

  modport slave (
    input  A, RnW, nLATCH0, nLATCH1, D, RAM_Q,
    output RAM_A, RAM_WE, RAM_D, RAM_SEL, PHASE, MDO, SDO, MVALID, SVALID, LATCH0_Q, LATCH1_Q
  );

endinterface

// File: rtl/bus_phase_counter.sv
// Free-running 4-phase bus slot counter; nresync_i low forces phase 0 on the next edge.
module bus_phase_counter
  import system86_bus_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   nresync_i,
  output phase_e phase_o
);

  phase_e phase_q, phase_d;

  always_comb begin
    phase_d = phase_e'(phase_q + 2'd1);
    if (!nresync_i) phase_d = PH_MAIN;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) phase_q <= PH_MAIN;
    else       phase_q <= phase_d;
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/shared_bus_responder.sv
// Shared-RAM / latch responder for the main and sub masters on the multiplexed bus.
// Latch readback is compiled in only with SHARED_BUS_LATCH_READBACK_EN defined.
module shared_bus_responder
  import system86_bus_pkg::*;
(
  input  logic CLK_6M,
  input  logic rst,
  input  logic nRESYNC,
  shared_bus_responder_if.slave bus
);

  phase_e  ph;
  region_e rgn;
  logic    cap;
  logic [DATA_W-1:0] rd_data;

  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic s1_sub_q, s1_sub_d, s1_rnw_q, s1_rnw_d, s1_l0_q, s1_l0_d, s1_l1_q, s1_l1_d;
  logic [DATA_W-1:0] s1_dat_q, s1_dat_d;
  logic s2_sub_q, s2_sub_d, s2_lat_q, s2_lat_d;
`ifdef SHARED_BUS_LATCH_READBACK_EN
  logic s2_l0_q, s2_l0_d;
`endif

  logic [RAM_AW-1:0] ram_a_q, ram_a_d;
  logic              ram_sel_q, ram_sel_d, ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_d_q, ram_d_d;
  logic [DATA_W-1:0] mdo_q, mdo_d, sdo_q, sdo_d, lat0_q, lat0_d, lat1_q, lat1_d;
  logic              mval_q, mval_d, sval_q, sval_d;

  bus_phase_counter u_phase (
    .clk_i     (CLK_6M),
    .rst_i     (rst),
    .nresync_i (nRESYNC),
    .phase_o   (ph)
  );

  always_comb begin
    rgn      = decode_region(bus.A[ADDR_W-1], bus.nLATCH0, bus.nLATCH1);
    cap      = ((ph == PH_MAIN) || (ph == PH_SUB)) && nRESYNC;
    rd_data  = bus.RAM_Q;
    vld_d    = '0;
    s1_sub_d = s1_sub_q;
    s1_rnw_d = s1_rnw_q;
    s1_l0_d  = s1_l0_q;
    s1_l1_d  = s1_l1_q;
    s1_dat_d = s1_dat_q;
    s2_sub_d = s2_sub_q;
    s2_lat_d = s2_lat_q;
`ifdef SHARED_BUS_LATCH_READBACK_EN
    s2_l0_d  = s2_l0_q;
`endif
    ram_a_d   = ram_a_q;
    ram_sel_d = ram_sel_q;
    ram_d_d   = ram_d_q;
    ram_we_d  = 1'b0;
    mdo_d     = mdo_q;
    sdo_d     = sdo_q;
    mval_d    = 1'b0;
    sval_d    = 1'b0;
    lat0_d    = lat0_q;
    lat1_d    = lat1_q;

    if (cap) begin
      vld_d[0] = 1'b1;
      s1_sub_d = (ph == PH_SUB);
      s1_rnw_d = bus.RnW;
      s1_l0_d  = !bus.nLATCH0;
      s1_l1_d  = !bus.nLATCH1;
      s1_dat_d = bus.D;
      if (rgn != RGN_LATCH) begin
        ram_a_d   = bus.A[RAM_AW-1:0];
        ram_sel_d = (rgn == RGN_RAM1);
        ram_d_d   = bus.D;
        ram_we_d  = !bus.RnW;
      end
    end

    // A low nRESYNC kills both stages, so nothing in flight retires.
    if (nRESYNC && vld_q[0]) begin
      if (s1_rnw_q) begin
        vld_d[1] = 1'b1;
        s2_sub_d = s1_sub_q;
        s2_lat_d = s1_l0_q || s1_l1_q;
`ifdef SHARED_BUS_LATCH_READBACK_EN
        s2_l0_d  = s1_l0_q;
`endif
      end else begin
        if (s1_l0_q) lat0_d = s1_dat_q;
        if (s1_l1_q) lat1_d = s1_dat_q;
      end
    end

    if (nRESYNC && vld_q[1]) begin
      if (s2_lat_q) begin
`ifdef SHARED_BUS_LATCH_READBACK_EN
        rd_data = s2_l0_q ? lat0_q : lat1_q;
`else
        rd_data = OPEN_BUS;
`endif
      end
      if (s2_sub_q) begin
        sdo_d  = rd_data;
        sval_d = 1'b1;
      end else begin
        mdo_d  = rd_data;
        mval_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_6M or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      s1_sub_q  <= 1'b0;
      s1_rnw_q  <= 1'b0;
      s1_l0_q   <= 1'b0;
      s1_l1_q   <= 1'b0;
      s1_dat_q  <= '0;
      s2_sub_q  <= 1'b0;
      s2_lat_q  <= 1'b0;
`ifdef SHARED_BUS_LATCH_READBACK_EN
      s2_l0_q   <= 1'b0;
`endif
      ram_a_q   <= '0;
      ram_sel_q <= 1'b0;
      ram_d_q   <= '0;
      ram_we_q  <= 1'b0;
      mdo_q     <= '0;
      sdo_q     <= '0;
      mval_q    <= 1'b0;
      sval_q    <= 1'b0;
      lat0_q    <= '0;
      lat1_q    <= '0;
    end else begin
      vld_q     <= vld_d;
      s1_sub_q  <= s1_sub_d;
      s1_rnw_q  <= s1_rnw_d;
      s1_l0_q   <= s1_l0_d;
      s1_l1_q   <= s1_l1_d;
      s1_dat_q  <= s1_dat_d;
      s2_sub_q  <= s2_sub_d;
      s2_lat_q  <= s2_lat_d;
`ifdef SHARED_BUS_LATCH_READBACK_EN
      s2_l0_q   <= s2_l0_d;
`endif
      ram_a_q   <= ram_a_d;
      ram_sel_q <= ram_sel_d;
      ram_d_q   <= ram_d_d;
      ram_we_q  <= ram_we_d;
      mdo_q     <= mdo_d;
      sdo_q     <= sdo_d;
      mval_q    <= mval_d;
      sval_q    <= sval_d;
      lat0_q    <= lat0_d;
      lat1_q    <= lat1_d;
    end
  end

  assign bus.PHASE    = ph;
  assign bus.RAM_A    = ram_a_q;
  assign bus.RAM_SEL  = ram_sel_q;
  assign bus.RAM_D    = ram_d_q;
  assign bus.RAM_WE   = ram_we_q;
  assign bus.MDO      = mdo_q;
  assign bus.SDO      = sdo_q;
  assign bus.MVALID   = mval_q;
  assign bus.SVALID   = sval_q;
  assign bus.LATCH0_Q = lat0_q;
  assign bus.LATCH1_Q = lat1_q;

endmodule

// File: tb/tb_shared_bus_responder.sv
// Bench for shared_bus_responder: transaction-level model checked every cycle,
// plus directed literal checks of the key scenarios.
module tb_shared_bus_responder;
  import system86_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nresync = 1'b1;

  shared_bus_responder_if bus();

  shared_bus_responder dut (
    .CLK_6M  (clk),
    .rst     (rst),
    .nRESYNC (nresync),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] env_ram [2][4096];
  logic [7:0] m_mem   [2][4096];

  typedef struct {
    int         cap;
    bit         sub;
    bit         rnw;
    bit         l0;
    bit         l1;
    bit         sel;
    logic [11:0] a;
    logic [7:0]  d;
  } txn_t;

  txn_t pend[$];
  int          n = 0;
  logic [1:0]  m_ph = 2'd0;
  logic [11:0] e_a = '0;
  logic        e_sel = 1'b0, e_we = 1'b0, e_mv = 1'b0, e_sv = 1'b0;
  logic [7:0]  e_rd = '0, e_mdo = '0, e_sdo = '0, e_l0 = '0, e_l1 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Environment RAM: asynchronous read presented on the falling edge.
  always @(negedge clk) begin
    if (bus.RAM_WE === 1'b1) env_ram[bus.RAM_SEL][bus.RAM_A] = bus.RAM_D;
    bus.RAM_Q = env_ram[bus.RAM_SEL][bus.RAM_A];
  end

  task automatic model_step();
    txn_t keep[$];
    txn_t t;
    logic [7:0] rd;
    if (rst) begin
      pend.delete();
      m_ph = 0; e_a = 0; e_sel = 0; e_we = 0; e_rd = 0;
      e_mdo = 0; e_sdo = 0; e_mv = 0; e_sv = 0; e_l0 = 0; e_l1 = 0;
      n++;
      return;
    end
    e_we = 0; e_mv = 0; e_sv = 0;
    if (nresync) begin
      foreach (pend[i]) begin
        t = pend[i];
        if (t.rnw && (n - t.cap == 2)) begin
          if (t.l0 || t.l1) begin
`ifdef SHARED_BUS_LATCH_READBACK_EN
            rd = t.l0 ? e_l0 : e_l1;
`else
            rd = 8'hFF;
`endif
          end else begin
            rd = m_mem[t.sel][t.a];
          end
          if (t.sub) begin e_sdo = rd; e_sv = 1; end
          else       begin e_mdo = rd; e_mv = 1; end
        end else if (!t.rnw && (n - t.cap == 1)) begin
          if (t.l0) e_l0 = t.d;
          if (t.l1) e_l1 = t.d;
        end else if (n - t.cap < 2) begin
          keep.push_back(t);
        end
      end
    end
    pend = keep;
    if ((m_ph == 2'd0 || m_ph == 2'd2) && nresync) begin
      t.cap = n; t.sub = (m_ph == 2'd2); t.rnw = bus.RnW;
      t.l0 = !bus.nLATCH0; t.l1 = !bus.nLATCH1;
      t.sel = bus.A[12]; t.a = bus.A[11:0]; t.d = bus.D;
      pend.push_back(t);
      if (!t.l0 && !t.l1) begin
        e_a = t.a; e_sel = t.sel; e_rd = t.d; e_we = !t.rnw;
        if (!t.rnw) m_mem[t.sel][t.a] = t.d;
      end
    end
    m_ph = nresync ? m_ph + 2'd1 : 2'd0;
    n++;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("PHASE",    bus.PHASE,    m_ph);
    chk("RAM_A",    bus.RAM_A,    e_a);
    chk("RAM_SEL",  bus.RAM_SEL,  e_sel);
    chk("RAM_D",    bus.RAM_D,    e_rd);
    chk("RAM_WE",   bus.RAM_WE,   e_we);
    chk("MDO",      bus.MDO,      e_mdo);
    chk("SDO",      bus.SDO,      e_sdo);
    chk("MVALID",   bus.MVALID,   e_mv);
    chk("SVALID",   bus.SVALID,   e_sv);
    chk("LATCH0_Q", bus.LATCH0_Q, e_l0);
    chk("LATCH1_Q", bus.LATCH1_Q, e_l1);
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic drive(input logic [12:0] a, input logic rnw, input logic nl0, input logic nl1,
                       input logic [7:0] d);
    bus.A = a; bus.RnW = rnw; bus.nLATCH0 = nl0; bus.nLATCH1 = nl1; bus.D = d;
  endtask

  task automatic idle();
    drive(13'h0FFF, 1'b0, 1'b1, 1'b1, 8'h00);
  endtask

  task automatic align(input logic [1:0] p);
    for (int i = 0; i < 8 && m_ph != p; i++) nxt();
    chk("align_phase", m_ph, p);
  endtask

  // Returns on the falling edge right after the capture edge, bus idle.
  task automatic xact(input logic [1:0] p, input logic [12:0] a, input logic rnw,
                      input logic nl0, input logic nl1, input logic [7:0] d);
    idle();
    align(p);
    drive(a, rnw, nl0, nl1, d);
    nxt();
    idle();
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_PHASE"},   bus.PHASE,    0);
    chk({tag, "_RAM_A"},   bus.RAM_A,    0);
    chk({tag, "_RAM_SEL"}, bus.RAM_SEL,  0);
    chk({tag, "_RAM_WE"},  bus.RAM_WE,   0);
    chk({tag, "_RAM_D"},   bus.RAM_D,    0);
    chk({tag, "_MDO"},     bus.MDO,      0);
    chk({tag, "_SDO"},     bus.SDO,      0);
    chk({tag, "_MVALID"},  bus.MVALID,   0);
    chk({tag, "_SVALID"},  bus.SVALID,   0);
    chk({tag, "_LATCH0"},  bus.LATCH0_Q, 0);
    chk({tag, "_LATCH1"},  bus.LATCH1_Q, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_lrd;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4096; a++) begin
        env_ram[s][a] = 8'(a) ^ ((s != 0) ? 8'hA5 : 8'h3C);
        m_mem[s][a]   = env_ram[s][a];
      end
    env_ram[1][12'hABC] = 8'hC3;
    m_mem[1][12'hABC]   = 8'hC3;
    idle();
    rst = 1'b1;
    nxt(); nxt();
    reset_vals("reset");
    rst = 1'b0;

    // Main write to RAM0
    xact(2'd0, 13'h0123, 1'b0, 1'b1, 1'b1, 8'h5A);
    chk("wr_RAM_SEL", bus.RAM_SEL, 0);
    chk("wr_RAM_A",   bus.RAM_A,   12'h123);
    chk("wr_RAM_D",   bus.RAM_D,   8'h5A);
    chk("wr_RAM_WE",  bus.RAM_WE,  1);
    nxt();
    chk("wr_RAM_WE_end", bus.RAM_WE, 0);

    // Sub read from RAM1
    xact(2'd2, 13'h1ABC, 1'b1, 1'b1, 1'b1, 8'h00);
    chk("rd_RAM_SEL", bus.RAM_SEL, 1);
    chk("rd_RAM_A",   bus.RAM_A,   12'hABC);
    chk("rd_RAM_WE",  bus.RAM_WE,  0);
    nxt(); nxt();
    chk("rd_SVALID", bus.SVALID, 1);
    chk("rd_SDO",    bus.SDO,    8'hC3);
    chk("rd_MDO",    bus.MDO,    8'h00);

    // Latch write to both, then latch read
    xact(2'd0, 13'h0000, 1'b0, 1'b0, 1'b0, 8'h99);
    chk("lw_RAM_WE", bus.RAM_WE, 0);
    nxt();
    chk("lw_LATCH0", bus.LATCH0_Q, 8'h99);
    chk("lw_LATCH1", bus.LATCH1_Q, 8'h99);
`ifdef SHARED_BUS_LATCH_READBACK_EN
    exp_lrd = 8'h99;
`else
    exp_lrd = 8'hFF;
`endif
    xact(2'd0, 13'h0000, 1'b1, 1'b0, 1'b0, 8'h00);
    nxt(); nxt();
    chk("lr_MVALID", bus.MVALID, 1);
    chk("lr_MDO",    bus.MDO,    exp_lrd);

    // Main and sub reads overlapping in the pipeline
    xact(2'd0, 13'h0ABC, 1'b1, 1'b1, 1'b1, 8'h00);
    nxt();
    drive(13'h1ABC, 1'b1, 1'b1, 1'b1, 8'h00);
    nxt();
    chk("ov_MVALID", bus.MVALID, 1);
    chk("ov_MDO",    bus.MDO,    8'h80);
    idle();
    nxt(); nxt();
    chk("ov_SVALID", bus.SVALID, 1);
    chk("ov_SDO",    bus.SDO,    8'hC3);

    // Junk writes in released phases only
    drive(13'h0010, 1'b1, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) nxt();
    for (int i = 0; i < 16; i++) begin
      if (m_ph == 2'd1 || m_ph == 2'd3)
        drive(13'($urandom), 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
      else
        drive(13'h0010, 1'b1, 1'b1, 1'b1, 8'h00);
      nxt();
      chk("rel_RAM_WE", bus.RAM_WE,   0);
      chk("rel_LATCH0", bus.LATCH0_Q, 8'h99);
      chk("rel_LATCH1", bus.LATCH1_Q, 8'h99);
    end

    // Resync cancels an in-flight main read
    xact(2'd0, 13'h0020, 1'b1, 1'b1, 1'b1, 8'h00);
    nresync = 1'b0;
    nxt();
    chk("rs_PHASE", bus.PHASE, 0);
    nresync = 1'b1;
    nxt();
    chk("rs_MVALID", bus.MVALID, 0);

    // Reset in the middle of a write
    xact(2'd0, 13'h0333, 1'b0, 1'b1, 1'b1, 8'h77);
    chk("mr_RAM_WE_pre", bus.RAM_WE, 1);
    rst = 1'b1;
    #1;
    reset_vals("midrst");
    nxt(); nxt();
    rst = 1'b0;
    drive(13'h1ABC, 1'b1, 1'b1, 1'b1, 8'h00);
    nxt();
    chk("mr_PHASE", bus.PHASE, 1);
    idle();
    nxt(); nxt();
    chk("mr_MVALID", bus.MVALID, 1);
    chk("mr_MDO",    bus.MDO,    8'hC3);
    nxt(); nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_bus_responder.md
SHARED_BUS_RESPONDER -- requirements
Module: shared_bus_responder

Interface
REQ-001 SHALL have ports, clock and reset first: CLK_6M in 1, master clock, all logic on rising edge; rst in 1, asynchronous active-high reset.
REQ-002 SHALL have nRESYNC in 1: active-low, sampled on CLK_6M; forces the phase counter to 0 on the next edge.
REQ-003 SHALL have A in 13, RnW in 1, nLATCH0 in 1, nLATCH1 in 1: time-multiplexed shared bus from the address multiplexer.
REQ-004 SHALL have D in 8 (bus write data) and RAM_Q in 8 (RAM read data, valid 1 cycle after RAM_A).
REQ-005 SHALL have RAM_A out 12, RAM_WE out 1, RAM_D out 8, RAM_SEL out 1: registered shared-RAM port; RAM_SEL 0=RAM0, 1=RAM1.
REQ-006 SHALL have PHASE out 2, MDO out 8, SDO out 8, MVALID out 1, SVALID out 1, LATCH0_Q out 8, LATCH1_Q out 8.

Function
REQ-007 SHALL run a 2-bit phase counter 0->1->2->3->0, one step per CLK_6M; bit0 = 1H, bit1 = 2H; PHASE = counter.
REQ-008 SHALL assign owners: phase 0 = main, phase 2 = sub, phases 1 and 3 = released (bus ignored).
REQ-009 SHALL register A, RnW, nLATCH0, nLATCH1 and D only in owner phases; released-phase inputs SHALL have no effect.
REQ-010 SHALL decode the captured address: A[12]=0 -> RAM0, A[12]=1 -> RAM1, RAM_A=A[11:0]; asserting nLATCH0 or nLATCH1 low overrides RAM decode (latch access, no RAM cycle).
REQ-011 SHALL drive RAM_A/RAM_SEL/RAM_D in the cycle after capture; RAM_WE SHALL pulse high exactly 1 cycle for a captured write (RnW=0), never for reads.
REQ-012 SHALL, for a RAM read, load RAM_Q into MDO (main) or SDO (sub) 2 cycles after capture, with MVALID/SVALID pulsing 1 cycle in that same cycle.
REQ-013 SHALL, for a latch write, load D into LATCH0_Q (nLATCH0 low) and/or LATCH1_Q (nLATCH1 low) 1 cycle after capture; both low writes both.
REQ-014 SHALL complete a latch read as a read returning 8'hFF via MDO/SDO with the usual valid pulse (see REQ-021 for the readback option).
REQ-015 SHALL hold MDO/SDO between valid pulses; each master's data register SHALL be touched only by that master's transactions.
REQ-016 SHALL allow main and sub transactions to overlap in the pipeline (2-deep); the pipeline SHALL never drop or reorder a transaction.
REQ-017 SHALL, on nRESYNC low, reset the counter to 0 and cancel every in-flight transaction: no RAM_WE, no latch write, no valid pulse for it.

Reset
REQ-018 SHALL on rst: phase counter 0, PHASE=0, RAM_A=0, RAM_SEL=0, RAM_WE=0, RAM_D=0, MDO=SDO=8'h00, MVALID=SVALID=0, LATCH0_Q=LATCH1_Q=8'h00, pipeline empty.
REQ-019 SHALL, on rst asserted mid-transaction, discard it; the first capture after release SHALL occur in phase 0.

Configuration
REQ-020 SHALL compile the latch readback feature only when SHARED_BUS_LATCH_READBACK_EN is defined.
REQ-021 SHALL, with SHARED_BUS_LATCH_READBACK_EN defined, return LATCH0_Q for a read with nLATCH0 low, LATCH1_Q with only nLATCH1 low, and LATCH0_Q when both are low; without the macro, latch reads SHALL return 8'hFF.

Structure
REQ-022 SHALL place phase encodings (PH_MAIN=0, PH_SUB=2), region codes, bus widths (13/12/8) and pipeline depth in shared package system86_bus_pkg.
REQ-023 SHALL implement the phase counter and its resync as sub-module bus_phase_counter; decode, pipeline and latches SHALL stay in shared_bus_responder.

Verification
REQ-024 Main write in phase 0, A=13'h0123, D=8'h5A, RnW=0 -> next cycle RAM_SEL=0, RAM_A=12'h123, RAM_D=8'h5A, RAM_WE=1 for 1 cycle.
REQ-025 Sub read in phase 2, A=13'h1ABC, with RAM_Q=8'hC3 -> RAM_SEL=1, RAM_A=12'hABC, RAM_WE=0; SDO=8'hC3 with SVALID pulse 2 cycles after capture; MDO unchanged.
REQ-026 Main write with nLATCH0=nLATCH1=0, D=8'h99 -> LATCH0_Q=LATCH1_Q=8'h99, RAM_WE stays 0; then a latch read returns 8'hFF without the macro, 8'h99 with it.
REQ-027 Bus toggled randomly with RnW=0 in phases 1 and 3 only -> no RAM_WE, no latch change, no valid pulses.
REQ-028 nRESYNC low in phase 1 after a main read capture -> PHASE=0 next cycle, no MVALID for that read; rst pulse mid-write -> all outputs at REQ-018 values, no RAM_WE.
